code_lock_fsm: RTL and testbench

- Upstream control stage for the four-digit seven-segment result display.
- Debounces a power button and four key buttons, collects a 4-key entry code, and compares it against a parameterised code.
- Drives the display's one-hot result flags: on, off, err, open.
- Holds open/err results for fixed timed intervals.

---
 rtl/code_lock_pkg.sv | 31 +++
 rtl/code_lock_fsm_if.sv | 21 ++
 rtl/code_lock_fsm_btn_debounce.sv | 39 +++
 rtl/code_lock_fsm.sv | 184 ++++++++++++++++++
 tb/tb_code_lock_fsm.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/code_lock_pkg.sv
// Shared types and constants for the code lock: state encoding, key index width, default code.
package code_lock_pkg;

  localparam int unsigned KEY_W    = 2;
  localparam int unsigned NUM_KEYS = 4;
  localparam logic [7:0]  DEFAULT_CODE = 8'h72;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ENTRY = 3'd2,
    ST_CHECK = 3'd3,
    ST_OPEN  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Index of the asserted key; callers only use it when exactly one key is pressed.
  function automatic logic [KEY_W-1:0] key_index(input logic [NUM_KEYS-1:0] onehot);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (onehot[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/code_lock_fsm_if.sv
// Button inputs and one-hot result flags between the lock controller and its neighbours.
interface code_lock_fsm_if;
  import code_lock_pkg::*;

  logic                btn_power;
  logic [NUM_KEYS-1:0] btn_key;
  logic                result_on;
  logic                result_off;
  logic                result_err;
  logic                result_open;

  modport master (
    output btn_power, btn_key,
    input  result_on, result_off, result_err, result_open
  );

  modport slave (
    input  btn_power, btn_key,
    output result_on, result_off, result_err, result_open
  );
endinterface

// File: rtl/code_lock_fsm_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, 1-cycle pulse on debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk_50MHz,
  input  logic reset_button_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Level flips only after the synchronised input has differed from it for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk_50MHz or negedge reset_button_n) begin
    if (!reset_button_n) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= sync[1];
      end else begin
        cnt <= CNT_W'(cnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/code_lock_fsm.sv
// Code lock controller: collects a CODE_LEN-key entry, compares it to CODE, drives one-hot result flags.
// Define CODE_LOCK_LOCKOUT_EN to add the consecutive-failure counter and LOCKOUT_CYCLES error hold.
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int unsigned               CODE_LEN             = 4,
  parameter logic [KEY_W*CODE_LEN-1:0] CODE                 = DEFAULT_CODE,
  parameter int unsigned               DEBOUNCE_CYCLES      = 500_000,
  parameter int unsigned               OPEN_CYCLES          = 250_000_000,
  parameter int unsigned               ERR_CYCLES           = 100_000_000,
  parameter int unsigned               ENTRY_TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned               MAX_TRIES            = 3,
  parameter int unsigned               LOCKOUT_CYCLES       = 1_500_000_000
) (
  input logic            clk_50MHz,
  input logic            reset_button_n,
  code_lock_fsm_if.slave lock_if
);

  localparam int unsigned CODE_W   = KEY_W * CODE_LEN;
  localparam int unsigned CNT_W    = $clog2(CODE_LEN + 1);
  localparam int unsigned MAX_HOLD = max2(max2(OPEN_CYCLES, ERR_CYCLES),
                                          max2(ENTRY_TIMEOUT_CYCLES, LOCKOUT_CYCLES));
  localparam int unsigned TMR_W    = $clog2(MAX_HOLD);

  logic                power_press;
  logic [NUM_KEYS-1:0] key_press;
  logic                key_single;
  logic [KEY_W-1:0]    key_idx;

  state_t              state, state_n;
  logic [CODE_W-1:0]   entry_buf, entry_buf_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [TMR_W-1:0]    timer, timer_n;
  logic                timer_clr;
  logic                err_lock;
  logic                result_on, result_off, result_err, result_open;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_power (
    .clk_50MHz      (clk_50MHz),
    .reset_button_n (reset_button_n),
    .btn            (lock_if.btn_power),
    .press          (power_press)
  );

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk_50MHz      (clk_50MHz),
      .reset_button_n (reset_button_n),
      .btn            (lock_if.btn_key[i]),
      .press          (key_press[i])
    );
  end

  // Simultaneous key presses are ambiguous, so a cycle with more than one pulse is dropped.
  assign key_single = ($countones(key_press) == 1);
  assign key_idx    = key_index(key_press);

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
  logic [FAIL_W-1:0] fail_cnt, fail_cnt_n;
  assign err_lock = (fail_cnt == FAIL_W'(MAX_TRIES));
`else
  logic unused_max_tries;
  assign err_lock         = 1'b0;
  assign unused_max_tries = ^(32'(MAX_TRIES));
`endif

  // Next-state, entry buffer and timer control.
  always_comb begin
    state_n     = state;
    entry_buf_n = entry_buf;
    cnt_n       = cnt;
    timer_clr   = 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
    fail_cnt_n  = fail_cnt;
`endif
    case (state)
      ST_OFF: begin
        if (power_press) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (power_press) begin
          state_n     = ST_OFF;
          entry_buf_n = '0;
          cnt_n       = '0;
        end else if (key_single) begin
          entry_buf_n[KEY_W-1:0] = key_idx;
          cnt_n                  = CNT_W'(1);
          state_n                = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (power_press) begin
          state_n     = ST_OFF;
          entry_buf_n = '0;
          cnt_n       = '0;
        end else if (key_single) begin
          entry_buf_n[int'(cnt)*KEY_W +: KEY_W] = key_idx;
          cnt_n     = CNT_W'(cnt + 1'b1);
          timer_clr = 1'b1;
          if (CNT_W'(cnt + 1'b1) == CNT_W'(CODE_LEN)) state_n = ST_CHECK;
        end else if (timer == TMR_W'(ENTRY_TIMEOUT_CYCLES - 1)) begin
          state_n     = ST_IDLE;
          entry_buf_n = '0;
          cnt_n       = '0;
        end
      end
      ST_CHECK: begin
        entry_buf_n = '0;
        cnt_n       = '0;
        if (entry_buf == CODE) begin
          state_n = ST_OPEN;
`ifdef CODE_LOCK_LOCKOUT_EN
          fail_cnt_n = '0;
`endif
        end else begin
          state_n = ST_ERR;
`ifdef CODE_LOCK_LOCKOUT_EN
          if (fail_cnt != FAIL_W'(MAX_TRIES)) fail_cnt_n = FAIL_W'(fail_cnt + 1'b1);
`endif
        end
      end
      ST_OPEN: begin
        if (power_press) begin
          state_n     = ST_OFF;
          entry_buf_n = '0;
          cnt_n       = '0;
        end else if (timer == TMR_W'(OPEN_CYCLES - 1)) begin
          state_n = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (timer == (err_lock ? TMR_W'(LOCKOUT_CYCLES - 1) : TMR_W'(ERR_CYCLES - 1))) begin
          state_n = ST_IDLE;
`ifdef CODE_LOCK_LOCKOUT_EN
          if (err_lock) fail_cnt_n = '0;
`endif
        end
      end
      default: begin
        state_n     = ST_OFF;
        entry_buf_n = '0;
        cnt_n       = '0;
      end
    endcase
    timer_n = (timer_clr || (state_n != state)) ? '0 : TMR_W'(timer + 1'b1);
  end

  // State register; result flags decode the next state so they change together with it.
  always_ff @(posedge clk_50MHz or negedge reset_button_n) begin
    if (!reset_button_n) begin
      state       <= ST_OFF;
      entry_buf   <= '0;
      cnt         <= '0;
      timer       <= '0;
`ifdef CODE_LOCK_LOCKOUT_EN
      fail_cnt    <= '0;
`endif
      result_on   <= 1'b0;
      result_off  <= 1'b1;
      result_err  <= 1'b0;
      result_open <= 1'b0;
    end else begin
      state       <= state_n;
      entry_buf   <= entry_buf_n;
      cnt         <= cnt_n;
      timer       <= timer_n;
`ifdef CODE_LOCK_LOCKOUT_EN
      fail_cnt    <= fail_cnt_n;
`endif
      result_on   <= (state_n == ST_IDLE) || (state_n == ST_ENTRY) || (state_n == ST_CHECK);
      result_off  <= (state_n == ST_OFF);
      result_err  <= (state_n == ST_ERR);
      result_open <= (state_n == ST_OPEN);
    end
  end

  assign lock_if.result_on   = result_on;
  assign lock_if.result_off  = result_off;
  assign lock_if.result_err  = result_err;
  assign lock_if.result_open = result_open;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: directed button sequences, a per-cycle behavioural model and literal timing checks.
module tb_code_lock_fsm;

  localparam int DEB      = 4;
  localparam int OPEN_C   = 20;
  localparam int ERR_C    = 10;
  localparam int TO_C     = 50;
  localparam int LOCK_C   = 40;
  localparam int MAX_T    = 3;
  localparam int CODE_LEN = 4;
`ifdef CODE_LOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
  localparam int EXP_THIRD_ERR = 40;
`else
  localparam bit LOCK_EN = 1'b0;
  localparam int EXP_THIRD_ERR = 10;
`endif

  logic clk_50MHz = 1'b0;
  logic reset_button_n;
  always #5 clk_50MHz = ~clk_50MHz;

  code_lock_fsm_if lock_if();

  code_lock_fsm #(
    .DEBOUNCE_CYCLES      (DEB),
    .OPEN_CYCLES          (OPEN_C),
    .ERR_CYCLES           (ERR_C),
    .ENTRY_TIMEOUT_CYCLES (TO_C),
    .LOCKOUT_CYCLES       (LOCK_C)
  ) dut (
    .clk_50MHz      (clk_50MHz),
    .reset_button_n (reset_button_n),
    .lock_if        (lock_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: debounce as "last DEB synchronised samples all differ from the level",
  // lock as a mode plus a queue of entered digits and a cycle age since the mode was entered.
  typedef enum int {M_OFF, M_IDLE, M_ENTRY, M_CHECK, M_OPEN, M_ERR} mode_t;
  mode_t        mm;
  int           entered[$];
  int           age;
  int           fails;
  int           err_hold;
  logic [DEB+1:0] hist [5];
  logic         lvl [5];
  logic         pls [5];
  logic [7:0]   tb_code = 8'h72;

  function automatic logic raw_in(input int b);
    return (b == 0) ? lock_if.btn_power : lock_if.btn_key[b-1];
  endfunction

  function automatic logic [3:0] model_flags();
    case (mm)
      M_OFF:   return 4'b0100;
      M_OPEN:  return 4'b0001;
      M_ERR:   return 4'b0010;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [3:0] dut_flags();
    return {lock_if.result_on, lock_if.result_off, lock_if.result_err, lock_if.result_open};
  endfunction

  task automatic model_reset();
    mm = M_OFF;
    entered.delete();
    age = 0;
    fails = 0;
    err_hold = ERR_C;
    for (int b = 0; b < 5; b++) begin
      hist[b] = '0;
      lvl[b]  = 1'b0;
      pls[b]  = 1'b0;
    end
  endtask

  task automatic model_fsm();
    int nk;
    int k;
    mode_t nx;
    bit clr;
    bit ok;
    nk = 0; k = 0; nx = mm; clr = 1'b0;
    for (int i = 0; i < 4; i++) if (pls[i+1]) begin nk++; k = i; end
    case (mm)
      M_OFF:  if (pls[0]) nx = M_IDLE;
      M_IDLE: begin
        if (pls[0]) begin nx = M_OFF; entered.delete(); end
        else if (nk == 1) begin entered.push_back(k); nx = M_ENTRY; end
      end
      M_ENTRY: begin
        if (pls[0]) begin nx = M_OFF; entered.delete(); end
        else if (nk == 1) begin
          entered.push_back(k);
          clr = 1'b1;
          if (entered.size() == CODE_LEN) nx = M_CHECK;
        end else if (age == TO_C - 1) begin nx = M_IDLE; entered.delete(); end
      end
      M_CHECK: begin
        ok = (entered.size() == CODE_LEN);
        for (int i = 0; i < CODE_LEN; i++)
          if (ok && entered[i] != int'((tb_code >> (2*i)) & 8'h3)) ok = 1'b0;
        if (ok) begin
          nx = M_OPEN;
          fails = 0;
        end else begin
          nx = M_ERR;
          if (fails < MAX_T) fails++;
          err_hold = (LOCK_EN && fails == MAX_T) ? LOCK_C : ERR_C;
        end
        entered.delete();
      end
      M_OPEN: begin
        if (pls[0]) begin nx = M_OFF; entered.delete(); end
        else if (age == OPEN_C - 1) nx = M_IDLE;
      end
      M_ERR: begin
        if (age == err_hold - 1) begin
          nx = M_IDLE;
          if (LOCK_EN && fails == MAX_T) fails = 0;
        end
      end
      default: nx = M_OFF;
    endcase
    if (nx != mm || clr) age = 0; else age++;
    mm = nx;
  endtask

  task automatic model_buttons();
    logic [DEB-1:0] w;
    logic flip;
    for (int b = 0; b < 5; b++) begin
      hist[b] = {hist[b][DEB:0], raw_in(b)};
      w       = hist[b][DEB+1:2];
      flip    = lvl[b] ? (w == '0) : (w == '1);
      pls[b]  = flip && !lvl[b];
      if (flip) lvl[b] = ~lvl[b];
    end
  endtask

  always @(posedge clk_50MHz or negedge reset_button_n) begin
    if (!reset_button_n) model_reset();
    else begin
      model_fsm();
      model_buttons();
    end
  end

  // Per-cycle comparison of the one-hot flags against the model.
  always @(negedge clk_50MHz) begin
    if (reset_button_n === 1'b1)
      check("flags_vs_model", int'(dut_flags()), int'(model_flags()));
  end

  function automatic logic flag_of(input int sel);
    case (sel)
      0:       return lock_if.result_on;
      1:       return lock_if.result_off;
      2:       return lock_if.result_err;
      default: return lock_if.result_open;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, input string name);
    int n;
    n = 0;
    while (!flag_of(sel) && n < limit) begin @(negedge clk_50MHz); n++; end
    check(name, int'(flag_of(sel)), 1);
  endtask

  task automatic run_len(input int sel, input int limit, output int len);
    len = 0;
    while (flag_of(sel) && len < limit) begin @(negedge clk_50MHz); len++; end
  endtask

  task automatic press_key(input int k, input int gap);
    lock_if.btn_key    = '0;
    lock_if.btn_key[k] = 1'b1;
    repeat (6) @(negedge clk_50MHz);
    lock_if.btn_key = '0;
    repeat (gap) @(negedge clk_50MHz);
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int d);
    press_key(a, 8);
    press_key(b, 8);
    press_key(c, 8);
    press_key(d, 0);
  endtask

  task automatic press_power();
    lock_if.btn_power = 1'b1;
    repeat (10) @(negedge clk_50MHz);
    lock_if.btn_power = 1'b0;
    repeat (8) @(negedge clk_50MHz);
  endtask

  initial begin
    int n;
    reset_button_n    = 1'b0;
    lock_if.btn_power = 1'b0;
    lock_if.btn_key   = '0;
    repeat (3) @(negedge clk_50MHz);
    reset_button_n = 1'b1;
    @(negedge clk_50MHz);
    check("reset_off",  int'(lock_if.result_off),  1);
    check("reset_on",   int'(lock_if.result_on),   0);
    check("reset_err",  int'(lock_if.result_err),  0);
    check("reset_open", int'(lock_if.result_open), 0);

    // 1: power on within 2+4+2 cycles
    lock_if.btn_power = 1'b1;
    n = 0;
    while (!lock_if.result_on && n < 10) begin @(negedge clk_50MHz); n++; end
    check("power_on_flag", int'(lock_if.result_on), 1);
    check("power_on_within_8", int'(n <= 8), 1);
    repeat (10 - n) @(negedge clk_50MHz);
    lock_if.btn_power = 1'b0;
    repeat (8) @(negedge clk_50MHz);

    // 2: correct code, exact latency and open hold
    press_key(2, 8); press_key(0, 8); press_key(3, 8);
    lock_if.btn_key = 4'b0010;
    repeat (6) @(negedge clk_50MHz);
    lock_if.btn_key = '0;
    @(negedge clk_50MHz);
    check("open_before_latency", int'(lock_if.result_open), 0);
    check("on_during_check",     int'(lock_if.result_on),   1);
    @(negedge clk_50MHz);
    check("open_latency", int'(lock_if.result_open), 1);
    run_len(3, 100, n);
    check("open_hold", n, 20);
    check("on_after_open", int'(lock_if.result_on), 1);

    // 3: wrong code, power ignored during err
    enter_code(2, 0, 3, 0);
    wait_for(2, 6, "err_start");
    lock_if.btn_power = 1'b1;
    n = 0;
    while (lock_if.result_err && n < 60) begin
      @(negedge clk_50MHz); n++;
      if (n == 6) lock_if.btn_power = 1'b0;
    end
    lock_if.btn_power = 1'b0;
    check("err_hold_power_ignored", n, 10);
    check("on_after_err", int'(lock_if.result_on), 1);
    repeat (8) @(negedge clk_50MHz);
    check("still_on_after_power_in_err", int'(lock_if.result_on), 1);

    // 4: partial entry timeout discards keys
    press_key(2, 8); press_key(0, 8);
    repeat (50) @(negedge clk_50MHz);
    check("on_after_timeout", int'(lock_if.result_on), 1);
    enter_code(2, 0, 3, 1);
    wait_for(3, 6, "open_after_timeout");
    run_len(3, 100, n);
    check("open_hold_t4", n, 20);

    // 5: glitch and simultaneous keys ignored mid-entry, then power off during open
    press_key(2, 8);
    lock_if.btn_key = 4'b0010;
    repeat (2) @(negedge clk_50MHz);
    lock_if.btn_key = '0;
    repeat (8) @(negedge clk_50MHz);
    lock_if.btn_key = 4'b1001;
    repeat (6) @(negedge clk_50MHz);
    lock_if.btn_key = '0;
    repeat (8) @(negedge clk_50MHz);
    press_key(0, 8); press_key(3, 8); press_key(1, 0);
    wait_for(3, 6, "open_after_glitch");
    lock_if.btn_power = 1'b1;
    wait_for(1, 10, "power_off_from_open");
    lock_if.btn_power = 1'b0;
    repeat (8) @(negedge clk_50MHz);
    press_power();
    check("on_again", int'(lock_if.result_on), 1);

    // 6: three consecutive failures
    enter_code(1, 1, 1, 1);
    wait_for(2, 6, "err1_start");
    run_len(2, 100, n);
    check("err1_hold", n, 10);
    enter_code(1, 1, 1, 1);
    wait_for(2, 6, "err2_start");
    run_len(2, 100, n);
    check("err2_hold", n, 10);
    enter_code(1, 1, 1, 1);
    wait_for(2, 6, "err3_start");
    run_len(2, 100, n);
    check("err3_hold", n, EXP_THIRD_ERR);
    enter_code(2, 0, 3, 1);
    wait_for(3, 6, "open_after_fails");
    run_len(3, 100, n);
    check("open_hold_t6", n, 20);

    // 7: keys ignored when off, async reset mid-entry
    press_power();
    check("off_from_idle", int'(lock_if.result_off), 1);
    press_key(2, 8);
    check("key_ignored_off", int'(lock_if.result_off), 1);
    press_power();
    check("on_before_reset", int'(lock_if.result_on), 1);
    press_key(2, 8);
    @(posedge clk_50MHz);
    #2 reset_button_n = 1'b0;
    #1;
    check("async_reset_off", int'(lock_if.result_off), 1);
    check("async_reset_on",  int'(lock_if.result_on),  0);
    repeat (2) @(negedge clk_50MHz);
    reset_button_n = 1'b1;
    @(negedge clk_50MHz);
    check("off_after_reset", int'(lock_if.result_off), 1);
    press_power();
    check("on_after_reset", int'(lock_if.result_on), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
